// File: rtl/knife_scheduler.sv
// Round controller for the 16x32 knife-dodging game: phase FSM, game tick,
// falling-knife slot pool with descent/retire/spawn, and player collision.

module knife_scheduler #(
    parameter int TICK_DIV  = 250,
    parameter int SLOTS     = 8,
    parameter int LIVES     = 3,
    parameter int HIT_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               function_btn,
    input  logic               left_btn,
    input  logic               right_btn,
    input  logic [4:0]         prn,
    input  logic [1:0]         difficulty,
    output logic [1:0]         state,
    output logic               tick,
    output logic [4:0]         human_col,
    output logic [SLOTS-1:0]   knife_valid,
    output logic [5*SLOTS-1:0] knife_col,
    output logic [4*SLOTS-1:0] knife_row,
    output logic [9:0]         score,
    output logic [1:0]         lives
);

    localparam int         CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         FW       = $clog2(HIT_TICKS + 1);
    localparam logic [4:0] HOME_COL = 5'd14;
    localparam logic [4:0] MAX_COL  = 5'd27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_tick, w_tick_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [FW-1:0]    r_freeze, w_freeze_next;
    logic [1:0]       r_tidx, w_tidx_next;
    logic [4:0]       r_human_col, w_hcol_next, w_hcol_mv;
    logic [9:0]       r_score, w_score_next, w_score_sat;
    logic [1:0]       r_lives, w_lives_next;
    logic             r_fb_s, r_fb_prev;
    logic [SLOTS-1:0] r_valid, w_valid_next;
    logic [4:0]       r_col      [SLOTS];
    logic [4:0]       w_col_next [SLOTS];
    logic [3:0]       r_row      [SLOTS];
    logic [3:0]       w_row_next [SLOTS];

    logic [SLOTS-1:0] w_dvalid, w_retire, w_sp1, w_sp2, w_take1, w_take2, w_uvalid, w_hitv;
    logic [3:0]       w_drow [SLOTS];
    logic [3:0]       w_urow [SLOTS];
    logic [4:0]       w_ucol [SLOTS];
    logic [4:0]       w_retire_cnt;
    logic [10:0]      w_score_sum;
    logic [4:0]       w_col2;
    logic             w_start, w_term, w_spawn_on, w_spawn_two;

    // Edge detect runs on two registered samples so the start lands one cycle after the press is seen.
    assign w_start     = r_fb_s & ~r_fb_prev;
    assign w_term      = (r_cnt == CW'(TICK_DIV - 1));
    assign w_col2      = {prn[0], prn[4:1]};
    assign w_spawn_on  = (difficulty == 2'd0) ? (r_tidx == 2'd0) :
                         (difficulty == 2'd1) ? ~r_tidx[0] : 1'b1;
    assign w_spawn_two = (difficulty == 2'd3);

    always_comb begin
        w_hcol_mv = r_human_col;
        if (right_btn && !left_btn && (r_human_col < MAX_COL))
            w_hcol_mv = r_human_col + 5'd1;
        else if (left_btn && !right_btn && (r_human_col != 5'd0))
            w_hcol_mv = r_human_col - 5'd1;
    end

    // Per-slot descent, spawn merge and collision, all on post-update values.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign w_retire[gi] = r_valid[gi] && (r_row[gi] == 4'd0);
            assign w_dvalid[gi] = r_valid[gi] && (r_row[gi] != 4'd0);
            assign w_drow[gi]   = w_dvalid[gi] ? (r_row[gi] - 4'd1) : r_row[gi];
            assign w_take1[gi]  = w_sp1[gi] & w_spawn_on;
            assign w_take2[gi]  = w_sp2[gi] & w_spawn_on & w_spawn_two;
            assign w_uvalid[gi] = w_dvalid[gi] | w_take1[gi] | w_take2[gi];
            assign w_urow[gi]   = (w_take1[gi] | w_take2[gi]) ? 4'd15 : w_drow[gi];
            assign w_ucol[gi]   = w_take1[gi] ? prn : (w_take2[gi] ? w_col2 : r_col[gi]);
            assign w_hitv[gi]   = w_uvalid[gi] && (w_urow[gi] <= 4'd5) &&
                                  ({1'b0, w_ucol[gi]} >= {1'b0, w_hcol_mv}) &&
                                  ({1'b0, w_ucol[gi]} <= ({1'b0, w_hcol_mv} + 6'd4));
            assign knife_col[5*gi +: 5] = r_col[gi];
            assign knife_row[4*gi +: 4] = r_row[gi];
        end
    endgenerate

    // Lowest and second-lowest free slots after retirement.
    always_comb begin
        logic found1, found2;
        found1 = 1'b0;
        found2 = 1'b0;
        w_sp1  = '0;
        w_sp2  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!w_dvalid[i]) begin
                if (!found1) begin
                    w_sp1[i] = 1'b1;
                    found1   = 1'b1;
                end else if (!found2) begin
                    w_sp2[i] = 1'b1;
                    found2   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_retire_cnt = '0;
        for (int i = 0; i < SLOTS; i++)
            w_retire_cnt = w_retire_cnt + 5'(w_retire[i]);
        w_score_sum = {1'b0, r_score} + {6'd0, w_retire_cnt};
        w_score_sat = (w_score_sum > 11'd1023) ? 10'd1023 : w_score_sum[9:0];
    end

    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = 1'b0;
        w_cnt_next    = r_cnt;
        w_freeze_next = r_freeze;
        w_tidx_next   = r_tidx;
        w_hcol_next   = r_human_col;
        w_score_next  = r_score;
        w_lives_next  = r_lives;
        w_valid_next  = r_valid;
        for (int i = 0; i < SLOTS; i++) begin
            w_col_next[i] = r_col[i];
            w_row_next[i] = r_row[i];
        end
        unique case (r_state)
            S_IDLE: begin
                w_valid_next = '0;
                for (int i = 0; i < SLOTS; i++) begin
                    w_col_next[i] = '0;
                    w_row_next[i] = '0;
                end
                w_score_next = '0;
                w_lives_next = 2'(LIVES);
                w_hcol_next  = HOME_COL;
                w_cnt_next   = '0;
                if (w_start)
                    w_state_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_term) begin
                    w_cnt_next  = '0;
                    w_tick_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (r_tick) begin
                    w_hcol_next  = w_hcol_mv;
                    w_tidx_next  = r_tidx + 2'd1;
                    w_score_next = w_score_sat;
                    if (|w_hitv) begin
                        w_lives_next = r_lives - 2'd1;
                        w_valid_next = '0;
                        for (int i = 0; i < SLOTS; i++) begin
                            w_col_next[i] = '0;
                            w_row_next[i] = '0;
                        end
                        if (r_lives == 2'd1) begin
                            w_state_next = S_OVER;
                        end else begin
                            w_state_next  = S_HIT;
                            w_freeze_next = FW'(HIT_TICKS);
                        end
                    end else begin
                        w_valid_next = w_uvalid;
                        for (int i = 0; i < SLOTS; i++) begin
                            w_col_next[i] = w_ucol[i];
                            w_row_next[i] = w_urow[i];
                        end
                    end
                end
            end
            S_HIT: begin
                if (w_term) begin
                    w_cnt_next = '0;
                    if (r_freeze <= FW'(1)) begin
                        w_freeze_next = '0;
                        w_state_next  = S_PLAY;
                    end else begin
                        w_freeze_next = r_freeze - FW'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_OVER: begin
                w_cnt_next = '0;
                if (w_start)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tick      <= 1'b0;
            r_cnt       <= '0;
            r_freeze    <= '0;
            r_tidx      <= '0;
            r_human_col <= HOME_COL;
            r_score     <= '0;
            r_lives     <= 2'(LIVES);
            r_fb_s      <= 1'b0;
            r_fb_prev   <= 1'b0;
            r_valid     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_col[i] <= '0;
                r_row[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_cnt       <= w_cnt_next;
            r_freeze    <= w_freeze_next;
            r_tidx      <= w_tidx_next;
            r_human_col <= w_hcol_next;
            r_score     <= w_score_next;
            r_lives     <= w_lives_next;
            r_fb_s      <= function_btn;
            r_fb_prev   <= r_fb_s;
            r_valid     <= w_valid_next;
            for (int i = 0; i < SLOTS; i++) begin
                r_col[i] <= w_col_next[i];
                r_row[i] <= w_row_next[i];
            end
        end
    end

    assign state       = r_state;
    assign tick        = r_tick;
    assign human_col   = r_human_col;
    assign knife_valid = r_valid;
    assign score       = r_score;
    assign lives       = r_lives;

endmodule

// File: tb/tb_knife_scheduler.sv
// Directed bench for knife_scheduler: reset/start, movement, spawn/descent,
// full pool, collision/HIT/OVER and reset during a tick update.
`timescale 1ns/1ps

module tb_knife_scheduler;

    localparam int TICK_DIV = 250;
    localparam int SLOTS    = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               function_btn = 1'b0;
    logic               left_btn = 1'b0;
    logic               right_btn = 1'b0;
    logic [4:0]         prn = 5'd0;
    logic [1:0]         difficulty = 2'd0;
    logic [1:0]         state;
    logic               tick;
    logic [4:0]         human_col;
    logic [SLOTS-1:0]   knife_valid;
    logic [5*SLOTS-1:0] knife_col;
    logic [4*SLOTS-1:0] knife_row;
    logic [9:0]         score;
    logic [1:0]         lives;

    int n_total = 0;
    int n_bad   = 0;
    int n_tick  = 0;

    knife_scheduler #(
        .TICK_DIV(TICK_DIV), .SLOTS(SLOTS), .LIVES(3), .HIT_TICKS(8)
    ) dut (
        .clk(clk), .rst(rst), .function_btn(function_btn), .left_btn(left_btn),
        .right_btn(right_btn), .prn(prn), .difficulty(difficulty), .state(state),
        .tick(tick), .human_col(human_col), .knife_valid(knife_valid),
        .knife_col(knife_col), .knife_row(knife_row), .score(score), .lives(lives)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; function_btn = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Ends on the negedge after the edge that enters PLAY.
    task automatic start_game();
        function_btn = 1'b1;
        repeat (2) @(negedge clk);
        function_btn = 1'b0;
    endtask

    // Waits for the tick pulse, then returns one cycle later with the update visible.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int k = 0; k < TICK_DIV + 10; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin seen = 1'b1; break; end
        end
        n_total++;
        if (!seen) begin n_bad++; $display("FAIL tick_timeout got=none exp=pulse"); end
        @(negedge clk);
        n_tick++;
        $display("tick %0d: state=%0d hcol=%0d valid=%h rows=%h score=%0d lives=%0d",
                 n_tick, state, human_col, knife_valid, knife_row, score, lives);
    endtask

    task automatic test_reset();
        do_reset();
        $display("reset: state=%0d lives=%0d hcol=%0d", state, lives, human_col);
        n_total++; if (state !== 2'd0)      begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_total++; if (lives !== 2'd3)      begin n_bad++; $display("FAIL rst_lives got=%0d exp=3", lives); end
        n_total++; if (human_col !== 5'd14) begin n_bad++; $display("FAIL rst_hcol got=%0d exp=14", human_col); end
        n_total++; if (tick !== 1'b0 || score !== 10'd0) begin n_bad++; $display("FAIL rst_tick_score got=%0d/%0d exp=0/0", tick, score); end
        n_total++; if (knife_valid !== '0 || knife_col !== '0 || knife_row !== '0)
            begin n_bad++; $display("FAIL rst_slots got=%h/%h/%h exp=0", knife_valid, knife_col, knife_row); end
        function_btn = 1'b1;
        @(negedge clk);
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL start_early got=%0d exp=0", state); end
        @(negedge clk);
        function_btn = 1'b0;
        $display("start: state=%0d", state);
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_play got=%0d exp=1", state); end
        repeat (TICK_DIV - 1) @(negedge clk);
        n_total++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_early got=%0d exp=0", tick); end
        @(negedge clk);
        n_total++; if (tick !== 1'b1) begin n_bad++; $display("FAIL first_tick got=%0d exp=1", tick); end
        @(negedge clk);
        n_total++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_width got=%0d exp=0", tick); end
    endtask

    task automatic test_movement();
        int exp_col;
        do_reset();
        difficulty = 2'd0; prn = 5'd0; right_btn = 1'b1;
        start_game();
        for (int k = 1; k <= 20; k++) begin
            wait_tick();
            exp_col = (14 + k > 27) ? 27 : 14 + k;
            n_total++; if (human_col !== 5'(exp_col)) begin n_bad++; $display("FAIL move_right got=%0d exp=%0d", human_col, exp_col); end
        end
        right_btn = 1'b0; left_btn = 1'b1; prn = 5'd31;
        for (int k = 1; k <= 40; k++) begin
            wait_tick();
            exp_col = (27 - k < 0) ? 0 : 27 - k;
            n_total++; if (human_col !== 5'(exp_col)) begin n_bad++; $display("FAIL move_left got=%0d exp=%0d", human_col, exp_col); end
        end
        left_btn = 1'b0; right_btn = 1'b1;
        wait_tick();
        n_total++; if (human_col !== 5'd1) begin n_bad++; $display("FAIL move_step got=%0d exp=1", human_col); end
        left_btn = 1'b1;
        repeat (3) wait_tick();
        n_total++; if (human_col !== 5'd1) begin n_bad++; $display("FAIL move_both got=%0d exp=1", human_col); end
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL move_state got=%0d exp=1", state); end
        left_btn = 1'b0; right_btn = 1'b0;
    endtask

    task automatic test_spawn_descent();
        do_reset();
        difficulty = 2'd2; prn = 5'd3; right_btn = 1'b1;
        start_game();
        wait_tick();
        n_total++; if (knife_valid[0] !== 1'b1 || knife_col[4:0] !== 5'd3 || knife_row[3:0] !== 4'd15)
            begin n_bad++; $display("FAIL spawn_slot0 got=%0d/%0d/%0d exp=1/3/15", knife_valid[0], knife_col[4:0], knife_row[3:0]); end
        repeat (5) wait_tick();
        right_btn = 1'b0;
        n_total++; if (human_col !== 5'd20) begin n_bad++; $display("FAIL spawn_hcol got=%0d exp=20", human_col); end
        repeat (10) wait_tick();
        n_total++; if (knife_row[3:0] !== 4'd0 || knife_valid !== 8'hFF || score !== 10'd0)
            begin n_bad++; $display("FAIL descend_row0 got=%0d/%h/%0d exp=0/ff/0", knife_row[3:0], knife_valid, score); end
        wait_tick();
        n_total++; if (score !== 10'd1) begin n_bad++; $display("FAIL retire_score got=%0d exp=1", score); end
        n_total++; if (knife_valid[0] !== 1'b1 || knife_row[3:0] !== 4'd15 || knife_col[4:0] !== 5'd3)
            begin n_bad++; $display("FAIL respawn got=%0d/%0d/%0d exp=1/15/3", knife_valid[0], knife_row[3:0], knife_col[4:0]); end
        n_total++; if (knife_row[7:4] !== 4'd0) begin n_bad++; $display("FAIL slot1_row got=%0d exp=0", knife_row[7:4]); end
    endtask

    task automatic test_pool_full();
        logic [5*SLOTS-1:0] exp_col;
        for (int i = 0; i < SLOTS; i++) exp_col[5*i +: 5] = (i % 2 == 0) ? 5'd2 : 5'd1;
        do_reset();
        difficulty = 2'd3; prn = 5'd2;
        start_game();
        repeat (4) wait_tick();
        n_total++; if (knife_valid !== 8'hFF) begin n_bad++; $display("FAIL pool_valid got=%h exp=ff", knife_valid); end
        n_total++; if (knife_row !== 32'hFFEEDDCC) begin n_bad++; $display("FAIL pool_rows got=%h exp=ffeeddcc", knife_row); end
        n_total++; if (knife_col !== exp_col) begin n_bad++; $display("FAIL pool_cols got=%h exp=%h", knife_col, exp_col); end
        repeat (12) wait_tick();
        n_total++; if (knife_row !== 32'h33221100 || knife_col !== exp_col || score !== 10'd0)
            begin n_bad++; $display("FAIL pool_drop got=%h/%h/%0d exp=33221100/%h/0", knife_row, knife_col, score, exp_col); end
        wait_tick();
        n_total++; if (score !== 10'd2) begin n_bad++; $display("FAIL pool_score got=%0d exp=2", score); end
        n_total++; if (knife_row !== 32'h221100FF || knife_valid !== 8'hFF || knife_col !== exp_col)
            begin n_bad++; $display("FAIL pool_reuse got=%h/%h exp=221100ff/ff", knife_row, knife_valid); end
    endtask

    task automatic test_collision();
        bit saw_tick = 1'b0;
        bit seen     = 1'b0;
        do_reset();
        difficulty = 2'd2; prn = 5'd16;
        start_game();
        repeat (10) wait_tick();
        n_total++; if (state !== 2'd1 || knife_row[3:0] !== 4'd6 || lives !== 2'd3)
            begin n_bad++; $display("FAIL pre_hit got=%0d/%0d/%0d exp=1/6/3", state, knife_row[3:0], lives); end
        wait_tick();
        n_total++; if (state !== 2'd2 || lives !== 2'd2) begin n_bad++; $display("FAIL hit1 got=%0d/%0d exp=2/2", state, lives); end
        n_total++; if (knife_valid !== '0 || score !== 10'd0) begin n_bad++; $display("FAIL hit1_clear got=%h/%0d exp=0/0", knife_valid, score); end
        for (int k = 0; k < 8 * TICK_DIV - 2; k++) begin
            @(negedge clk);
            if (tick !== 1'b0) saw_tick = 1'b1;
        end
        n_total++; if (saw_tick) begin n_bad++; $display("FAIL hit_no_tick got=pulse exp=none"); end
        n_total++; if (state !== 2'd2) begin n_bad++; $display("FAIL freeze_len got=%0d exp=2", state); end
        @(negedge clk);
        $display("freeze end: state=%0d", state);
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL freeze_exit got=%0d exp=1", state); end
        repeat (11) wait_tick();
        n_total++; if (state !== 2'd2 || lives !== 2'd1) begin n_bad++; $display("FAIL hit2 got=%0d/%0d exp=2/1", state, lives); end
        for (int k = 0; k < 9 * TICK_DIV; k++) begin
            @(negedge clk);
            if (state === 2'd1) begin seen = 1'b1; break; end
        end
        n_total++; if (!seen) begin n_bad++; $display("FAIL hit2_exit got=%0d exp=1", state); end
        repeat (11) wait_tick();
        n_total++; if (state !== 2'd3 || lives !== 2'd0 || knife_valid !== '0)
            begin n_bad++; $display("FAIL over got=%0d/%0d/%h exp=3/0/0", state, lives, knife_valid); end
        saw_tick = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (tick !== 1'b0) saw_tick = 1'b1;
        end
        n_total++; if (state !== 2'd3 || score !== 10'd0 || lives !== 2'd0 || saw_tick)
            begin n_bad++; $display("FAIL over_frozen got=%0d/%0d/%0d/%0d exp=3/0/0/0", state, score, lives, saw_tick); end
        start_game();
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL over_to_idle got=%0d exp=0", state); end
        @(negedge clk);
        n_total++; if (lives !== 2'd3 || human_col !== 5'd14) begin n_bad++; $display("FAIL idle_restore got=%0d/%0d exp=3/14", lives, human_col); end
        @(negedge clk);
        start_game();
        $display("restart: state=%0d", state);
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL idle_to_play got=%0d exp=1", state); end
    endtask

    task automatic test_reset_mid_tick();
        bit seen = 1'b0;
        do_reset();
        difficulty = 2'd2; prn = 5'd3;
        start_game();
        repeat (16) wait_tick();
        n_total++; if (knife_valid !== 8'hFF || knife_row[3:0] !== 4'd0)
            begin n_bad++; $display("FAIL midrst_pre got=%h/%0d exp=ff/0", knife_valid, knife_row[3:0]); end
        for (int k = 0; k < TICK_DIV + 10; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin seen = 1'b1; break; end
        end
        n_total++; if (!seen) begin n_bad++; $display("FAIL midrst_tick got=none exp=pulse"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-tick reset: state=%0d score=%0d valid=%h", state, score, knife_valid);
        n_total++; if (score !== 10'd0 || knife_valid !== '0 || knife_row !== '0 || knife_col !== '0)
            begin n_bad++; $display("FAIL midrst_slots got=%0d/%h/%h/%h exp=0", score, knife_valid, knife_row, knife_col); end
        n_total++; if (state !== 2'd0 || tick !== 1'b0 || lives !== 2'd3 || human_col !== 5'd14)
            begin n_bad++; $display("FAIL midrst_status got=%0d/%0d/%0d/%0d exp=0/0/3/14", state, tick, lives, human_col); end
    endtask

    initial begin
        test_reset();
        test_movement();
        test_spawn_descent();
        test_pool_full();
        test_collision();
        test_reset_mid_tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
